// File: rtl/axi4lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axi4lite_reg_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int unsigned NUM_REGS = 4;

  // Byte offsets of the registers within the decode space
  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  // True when a decoded word index maps onto an implemented register
  function automatic logic idx_in_range(input logic [31:0] idx);
    return idx < 32'(NUM_REGS);
  endfunction

endpackage

// File: rtl/axi4lite_strb_merge.sv
// Combinational byte-enable merge: bytes with strb=1 come from new_data, the rest from old_data.
module axi4lite_strb_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Per-byte select between the old and new word
  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave with four 32-bit RW registers exported to the fabric.
// Optional macro AXI4LITE_REG_SLAVE_DECERR_EN: word indices above 3 return SLVERR
// (writes dropped, reads return 0); otherwise addresses alias on bits [3:2].
module axi4lite_reg_slave
  import axi4lite_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;

  logic          rst_done_q;
  logic          aw_held_q, w_held_q;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          bvalid_q, rvalid_q;
  resp_t         bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] regs_q [NUM_REGS];

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, wr_old, wr_merged, rd_val;
  logic [SW-1:0] wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [1:0]    wr_sel, rd_sel;
  logic          wr_ok, rd_ok;
  logic [NUM_REGS-1:0] wr_en;

  // Readies stay low in reset and rise on the first edge after it releases
  assign S_AXI_AWREADY = rst_done_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = rst_done_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Commit as soon as both halves are present, counting a handshake on this very edge
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;

  assign wr_idx = wr_addr[AW-1:2];
  assign rd_idx = S_AXI_ARADDR[AW-1:2];
  assign wr_sel = wr_idx[1:0];
  assign rd_sel = rd_idx[1:0];

  logic unused_bits;
`ifdef AXI4LITE_REG_SLAVE_DECERR_EN
  assign wr_ok = idx_in_range(32'(wr_idx));
  assign rd_ok = idx_in_range(32'(rd_idx));
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0],
                         wr_idx[IW-1:2], rd_idx[IW-1:2]};
`endif

  assign wr_old = regs_q[wr_sel];

  axi4lite_strb_merge #(
    .DATA_WIDTH(DW)
  ) u_strb_merge (
    .old_data(wr_old),
    .new_data(wr_data),
    .strb    (wr_strb),
    .merged  (wr_merged)
  );

  // Decode the committing write into a one-hot register enable
  always_comb begin
    wr_en = '0;
    if (commit && wr_ok) begin
      unique case ({wr_sel, 2'b00})
        REG0_OFFSET: wr_en[0] = 1'b1;
        REG1_OFFSET: wr_en[1] = 1'b1;
        REG2_OFFSET: wr_en[2] = 1'b1;
        REG3_OFFSET: wr_en[3] = 1'b1;
        default:     wr_en = '0;
      endcase
    end
  end

  // Read mux; out-of-range reads return zero
  always_comb begin
    rd_val = '0;
    if (rd_ok) begin
      unique case ({rd_sel, 2'b00})
        REG0_OFFSET: rd_val = regs_q[0];
        REG1_OFFSET: rd_val = regs_q[1];
        REG2_OFFSET: rd_val = regs_q[2];
        REG3_OFFSET: rd_val = regs_q[3];
        default:     rd_val = '0;
      endcase
    end
  end

  // Reset-release tracker gating all readies
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_done_q <= 1'b0;
    else        rst_done_q <= 1'b1;
  end

  // Hold an early AW until its W partner arrives
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
    end else if (commit) begin
      aw_held_q <= 1'b0;
    end else if (aw_hs) begin
      aw_held_q <= 1'b1;
      aw_addr_q <= S_AXI_AWADDR;
    end
  end

  // Hold an early W until its AW partner arrives
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_held_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      w_held_q <= 1'b0;
    end else if (w_hs) begin
      w_held_q <= 1'b1;
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
  end

  // Write response: raised on commit, held until BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? OKAY : SLVERR;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register file update
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) regs_q[i] <= wr_merged;
      end
    end
  end

  // Read data channel; samples pre-write contents on a shared edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_ok ? OKAY : SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

  assign REG0 = regs_q[0];
  assign REG1 = regs_q[1];
  assign REG2 = regs_q[2];
  assign REG3 = regs_q[3];

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed self-checking bench for axi4lite_reg_slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4lite_reg_slave;

  logic        clk;
  logic        rst;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0, reg1, reg2, reg3;

  int checks = 0;
  int errors = 0;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .REG0         (reg0),
    .REG1         (reg1),
    .REG2         (reg2),
    .REG3         (reg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full write with AW and W presented together; called on a falling edge
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp,
                          input string tag);
    logic aw_done, w_done;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int i = 0; i < 16 && !bvalid; i++) @(negedge clk);
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Full read; called on a falling edge
  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    logic ar_done;
    ar_done = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    for (int i = 0; i < 16 && !ar_done; i++) begin
      if (arready) ar_done = 1'b1;
      @(negedge clk);
    end
    arvalid = 1'b0;
    for (int i = 0; i < 16 && !rvalid; i++) @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_reg0", reg0, 32'd0);
    check("rst_reg3", reg3, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_awready_pre_edge", 32'(awready), 32'd0);
    @(negedge clk);
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // Sequential writes then readback
    do_write(6'h00, 32'd1, 4'hF, 2'b00, "wr0");
    do_write(6'h04, 32'd2, 4'hF, 2'b00, "wr1");
    do_write(6'h08, 32'd3, 4'hF, 2'b00, "wr2");
    do_write(6'h0C, 32'd4, 4'hF, 2'b00, "wr3");
    do_read(6'h00, 32'd1, 2'b00, "rd0");
    do_read(6'h04, 32'd2, 2'b00, "rd1");
    do_read(6'h08, 32'd3, 2'b00, "rd2");
    do_read(6'h0C, 32'd4, 2'b00, "rd3");
    check("reg1_out", reg1, 32'd2);

    // W three cycles ahead of AW
    wdata  = 32'hDEADBEEF;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    bready = 1'b0;
    check("wfirst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready_drop", 32'(wready), 32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("wfirst_reg2_old", reg2, 32'd3);
    awaddr  = 6'h08;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_bresp", 32'(bresp), 32'd0);
    check("wfirst_reg2", reg2, 32'hDEADBEEF);
    check("wfirst_awready_busy", 32'(awready), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("wfirst_bvalid_clr", 32'(bvalid), 32'd0);

    // Byte-strobe merge
    do_write(6'h04, 32'h11223344, 4'hF, 2'b00, "strb_init");
    do_write(6'h04, 32'hAABBCCDD, 4'b0101, 2'b00, "strb_wr");
    check("strb_reg1", reg1, 32'h11BB33DD);

    // Backpressure on both response channels
    awaddr = 6'h0C; wdata = 32'h55AA55AA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h00; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, 32'd1);
      check("bp_awready", 32'(awready), 32'd0);
      check("bp_arready", 32'(arready), 32'd0);
      @(negedge clk);
    end
    check("bp_reg3", reg3, 32'h55AA55AA);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("bp_bvalid_clr", 32'(bvalid), 32'd0);
    check("bp_rvalid_clr", 32'(rvalid), 32'd0);
    check("bp_awready_back", 32'(awready), 32'd1);
    check("bp_arready_back", 32'(arready), 32'd1);

    // Read and write to the same register on the same edge
    do_write(6'h04, 32'd5, 4'hF, 2'b00, "same_init");
    awaddr = 6'h04; wdata = 32'd9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_bvalid", 32'(bvalid), 32'd1);
    check("same_rvalid", 32'(rvalid), 32'd1);
    check("same_rdata_old", rdata, 32'd5);
    check("same_reg1_new", reg1, 32'd9);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(6'h04, 32'd9, 2'b00, "same_after");

    // Zero strobe: response OKAY, no change
    do_write(6'h08, 32'h12345678, 4'h0, 2'b00, "strb0");
    check("strb0_reg2", reg2, 32'hDEADBEEF);

    // Out-of-range word index
`ifdef AXI4LITE_REG_SLAVE_DECERR_EN
    do_write(6'h10, 32'hCAFEF00D, 4'hF, 2'b10, "oor_wr");
    check("oor_reg0", reg0, 32'd1);
    do_read(6'h10, 32'd0, 2'b10, "oor_rd");
`else
    do_write(6'h10, 32'hCAFEF00D, 4'hF, 2'b00, "alias_wr");
    check("alias_reg0", reg0, 32'hCAFEF00D);
    do_read(6'h10, 32'hCAFEF00D, 2'b00, "alias_rd");
    do_read(6'h00, 32'hCAFEF00D, 2'b00, "alias_rd0");
`endif

    // Reset while a W is held: it must be dropped
    wdata = 32'h12; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_wready", 32'(wready), 32'd0);
    check("mid_rst_awready", 32'(awready), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    check("mid_rst_reg2", reg2, 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_awready_pre_edge", 32'(awready), 32'd0);
    @(negedge clk);
    check("mid_rel_awready", 32'(awready), 32'd1);
    check("mid_rel_wready", 32'(wready), 32'd1);
    awaddr = 6'h00; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("mid_no_stale_commit", 32'(bvalid), 32'd0);
    wdata = 32'h77; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("mid_late_w_bvalid", 32'(bvalid), 32'd1);
    check("mid_late_w_reg0", reg0, 32'h77);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("mid_bvalid_clr", 32'(bvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
